sn_dispatch_arbiter: RTL and testbench

Shares one snooper among N_CORES packetfilter cores. Each cycle the block picks the next core advertising a free ping/pong buffer, using round-robin order filtered by an enable mask. It presents that core to the snooper as a single rdy_for_sn/ack endpoint, steers the packet writes and the done handshake to it, then moves on. It sits between the snooper and the packetfilter_core array at the top level.

---
 rtl/sn_dispatch_arbiter_pkg.sv | 23 ++
 rtl/sn_dispatch_arbiter_rr_pick.sv | 27 ++
 rtl/sn_dispatch_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sn_dispatch_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sn_dispatch_arbiter_pkg.sv
// sn_dispatch_pkg: shared definitions for the snooper dispatch arbiter.
//   state_t       : dispatch FSM encoding (IDLE / OFFER / WRITE / DONE)
//   sel_width()   : width of a core index, never narrower than 1 bit
//   *_CNT_*       : statistics counter widths and saturation value
package sn_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PKT_CNT_WIDTH  = 32;
  localparam int DROP_CNT_WIDTH = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = 16'hFFFF;

  // A single core still needs a 1-bit index port.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sn_dispatch_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req       in  N          request vector
//   last      in  SEL_WIDTH  index granted most recently
//   grant     out SEL_WIDTH  first requester after last, wrapping
//   any_valid out 1          at least one request is present
module rr_pick #(
  parameter int N         = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] last,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 any_valid
);

  // Scan last+1 .. last+N (mod N); the first hit wins and later hits are masked.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      grant     = (req[(int'(last) + i) % N] && !any_valid)
                  ? SEL_WIDTH'((int'(last) + i) % N) : grant;
      any_valid = any_valid | req[(int'(last) + i) % N];
    end
  end

endmodule

// File: rtl/sn_dispatch_arbiter.sv
// sn_dispatch_arbiter: shares one snooper among N_CORES packet filter cores.
// A free, enabled core buffer is chosen round-robin, offered to the snooper as
// a single rdy_for_sn/ack endpoint, then the packet writes and the done
// handshake are steered to that core.
// Ports:
//   clk, rst (async, active-low)      core_en          per-core enable mask
//   sn_addr/sn_wr_data/sn_wr_en/sn_byte_inc           snooper write side
//   sn_done / sn_done_ack             end-of-packet handshake with snooper
//   rdy_for_sn / rdy_for_sn_ack       buffer offer/claim with snooper
//   core_rdy_for_sn / core_rdy_for_sn_ack             per-core offer/claim
//   core_sn_addr/_wr_data/_byte_inc   registered broadcast write fields
//   core_sn_wr_en                     registered one-hot write strobe
//   core_sn_done / core_sn_done_ack   per-core done handshake
//   cur_sel, pkt_cnt, drop_wr_cnt     status
module sn_dispatch_arbiter
  import sn_dispatch_pkg::*;
#(
  parameter int N_CORES           = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int INC_WIDTH         = 4,
  parameter int SEL_WIDTH         = sel_width(N_CORES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CORES-1:0]           core_en,
  input  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
  input  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
  input  logic                         sn_wr_en,
  input  logic [INC_WIDTH-1:0]         sn_byte_inc,
  input  logic                         sn_done,
  output logic                         sn_done_ack,
  output logic                         rdy_for_sn,
  input  logic                         rdy_for_sn_ack,
  input  logic [N_CORES-1:0]           core_rdy_for_sn,
  output logic [N_CORES-1:0]           core_rdy_for_sn_ack,
  output logic [SN_FWD_ADDR_WIDTH-1:0] core_sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0] core_sn_wr_data,
  output logic [INC_WIDTH-1:0]         core_sn_byte_inc,
  output logic [N_CORES-1:0]           core_sn_wr_en,
  output logic [N_CORES-1:0]           core_sn_done,
  input  logic [N_CORES-1:0]           core_sn_done_ack,
  output logic [SEL_WIDTH-1:0]         cur_sel,
  output logic [PKT_CNT_WIDTH-1:0]     pkt_cnt,
  output logic [DROP_CNT_WIDTH-1:0]    drop_wr_cnt
);

  state_t                       state_r;
  state_t                       state_next_s;
  logic [SEL_WIDTH-1:0]         sel_r;
  logic [SEL_WIDTH-1:0]         last_r;
  logic [SEL_WIDTH-1:0]         pick_s;
  logic                         any_s;
  logic [N_CORES-1:0]           cand_s;
  logic [N_CORES-1:0]           sel_oh_s;
  logic                         sel_live_s;
  logic                         claim_s;
  logic                         done_ack_s;
  logic                         fwd_s;
  logic                         rdy_r;
  logic [N_CORES-1:0]           wr_en_r;
  logic [N_CORES-1:0]           done_r;
  logic [SN_FWD_ADDR_WIDTH-1:0] addr_r;
  logic [SN_FWD_DATA_WIDTH-1:0] data_r;
  logic [INC_WIDTH-1:0]         inc_r;
  logic [PKT_CNT_WIDTH-1:0]     pkt_r;
  logic [DROP_CNT_WIDTH-1:0]    drop_r;

  assign cand_s = core_rdy_for_sn & core_en;

  rr_pick #(
    .N         (N_CORES),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_pick (
    .req       (cand_s),
    .last      (last_r),
    .grant     (pick_s),
    .any_valid (any_s)
  );

  // One-hot decode of the selected core index.
  always_comb begin
    sel_oh_s = '0;
    for (int i = 0; i < N_CORES; i++) begin
      sel_oh_s[i] = (sel_r == SEL_WIDTH'(i));
    end
  end

  assign sel_live_s = |(sel_oh_s & cand_s);
  assign claim_s    = (state_r == ST_OFFER) && rdy_for_sn_ack;
  // done_r is only ever the selected core's bit, so any matching ack is from sel.
  assign done_ack_s = (state_r == ST_DONE) && (|(done_r & core_sn_done_ack));
  assign fwd_s      = (state_r == ST_WRITE) && sn_wr_en;

  // Next-state logic; a claim beats a simultaneous withdrawal.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) state_next_s = ST_OFFER;
        else       state_next_s = ST_IDLE;
      end
      ST_OFFER: begin
        if (rdy_for_sn_ack)   state_next_s = ST_WRITE;
        else if (!sel_live_s) state_next_s = ST_IDLE;
        else                  state_next_s = ST_OFFER;
      end
      ST_WRITE: begin
        if (sn_done) state_next_s = ST_DONE;
        else         state_next_s = ST_WRITE;
      end
      ST_DONE: begin
        if (done_ack_s) state_next_s = ST_IDLE;
        else            state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state, selection and round-robin pointer; reset makes core 0 first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b0;
      sel_r   <= '0;
      last_r  <= SEL_WIDTH'(N_CORES - 1);
    end else begin
      state_r <= state_next_s;
      rdy_r   <= (state_next_s == ST_OFFER);
      if ((state_r == ST_IDLE) && any_s) sel_r <= pick_s;
      if (done_ack_s) last_r <= sel_r;
    end
  end

  // Write forwarding: broadcast fields hold between writes, strobe is one-hot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      inc_r   <= '0;
    end else begin
      wr_en_r <= fwd_s ? sel_oh_s : '0;
      if (fwd_s) begin
        addr_r <= sn_addr;
        data_r <= sn_wr_data;
        inc_r  <= sn_byte_inc;
      end
    end
  end

  // Done request to the core, plus packet and dropped-write statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_r <= '0;
      pkt_r  <= '0;
      drop_r <= '0;
    end else begin
      done_r <= ((state_r == ST_DONE) && !done_ack_s) ? sel_oh_s : '0;
      if (done_ack_s) pkt_r <= pkt_r + 32'd1;
      if (sn_wr_en && (state_r != ST_WRITE) && (drop_r != DROP_CNT_MAX))
        drop_r <= drop_r + 16'd1;
    end
  end

  assign rdy_for_sn          = rdy_r;
  assign core_rdy_for_sn_ack = claim_s ? sel_oh_s : '0;
  assign sn_done_ack         = done_ack_s;
  assign core_sn_wr_en       = wr_en_r;
  assign core_sn_addr        = addr_r;
  assign core_sn_wr_data     = data_r;
  assign core_sn_byte_inc    = inc_r;
  assign core_sn_done        = done_r;
  assign cur_sel             = sel_r;
  assign pkt_cnt             = pkt_r;
  assign drop_wr_cnt         = drop_r;

endmodule

// File: tb/tb_sn_dispatch_arbiter.sv
// tb_sn_dispatch_arbiter: directed self-checking bench for sn_dispatch_arbiter
// with N_CORES=4. Inputs change on the falling edge; outputs are compared on
// the falling edge (registered) or 1 time unit later (combinational).
module tb_sn_dispatch_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  core_en;
  logic [7:0]  sn_addr;
  logic [63:0] sn_wr_data;
  logic        sn_wr_en;
  logic [3:0]  sn_byte_inc;
  logic        sn_done;
  logic        sn_done_ack;
  logic        rdy_for_sn;
  logic        rdy_for_sn_ack;
  logic [3:0]  core_rdy_for_sn;
  logic [3:0]  core_rdy_for_sn_ack;
  logic [7:0]  core_sn_addr;
  logic [63:0] core_sn_wr_data;
  logic [3:0]  core_sn_byte_inc;
  logic [3:0]  core_sn_wr_en;
  logic [3:0]  core_sn_done;
  logic [3:0]  core_sn_done_ack;
  logic [1:0]  cur_sel;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_wr_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_pkt = 0;

  sn_dispatch_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .core_en             (core_en),
    .sn_addr             (sn_addr),
    .sn_wr_data          (sn_wr_data),
    .sn_wr_en            (sn_wr_en),
    .sn_byte_inc         (sn_byte_inc),
    .sn_done             (sn_done),
    .sn_done_ack         (sn_done_ack),
    .rdy_for_sn          (rdy_for_sn),
    .rdy_for_sn_ack      (rdy_for_sn_ack),
    .core_rdy_for_sn     (core_rdy_for_sn),
    .core_rdy_for_sn_ack (core_rdy_for_sn_ack),
    .core_sn_addr        (core_sn_addr),
    .core_sn_wr_data     (core_sn_wr_data),
    .core_sn_byte_inc    (core_sn_byte_inc),
    .core_sn_wr_en       (core_sn_wr_en),
    .core_sn_done        (core_sn_done),
    .core_sn_done_ack    (core_sn_done_ack),
    .cur_sel             (cur_sel),
    .pkt_cnt             (pkt_cnt),
    .drop_wr_cnt         (drop_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [3:0] oh(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full packet; entered on a falling edge with the FSM idle and a candidate present.
  task automatic run_pkt(input int core, input int nwr, input logic [7:0] base,
                         input bit together, input bit withdraw, input int ack_delay);
    logic [7:0]  a;
    logic [63:0] d;
    step();
    chk("offer_rdy", rdy_for_sn, 1);
    chk("offer_sel", cur_sel, core);
    rdy_for_sn_ack = 1'b1;
    if (withdraw) core_rdy_for_sn = 4'b0000;
    #1;
    chk("claim_ack", core_rdy_for_sn_ack, oh(core));
    step();
    rdy_for_sn_ack = 1'b0;
    chk("write_rdy_low", rdy_for_sn, 0);
    chk("write_no_claim", core_rdy_for_sn_ack, 0);
    for (int k = 0; k < nwr; k++) begin
      a = base + 8'(k);
      d = {48'h5A5A_0000_C0DE, a, a} ^ (64'(core) << 40);
      sn_addr     = a;
      sn_wr_data  = d;
      sn_byte_inc = 4'(k + 1);
      sn_wr_en    = 1'b1;
      if (together && (k == nwr - 1)) sn_done = 1'b1;
      step();
      sn_wr_en = 1'b0;
      chk("wr_strobe", core_sn_wr_en, oh(core));
      chk("wr_addr", core_sn_addr, a);
      chk("wr_data", core_sn_wr_data, d);
      chk("wr_inc", core_sn_byte_inc, 4'(k + 1));
      chk("done_early", core_sn_done, 0);
    end
    if (!together) begin
      sn_done = 1'b1;
      step();
      chk("wr_gap", core_sn_wr_en, 0);
      chk("done_early2", core_sn_done, 0);
    end
    step();
    chk("wr_after", core_sn_wr_en, 0);
    chk("done_rise", core_sn_done, oh(core));
    core_sn_done_ack = ~oh(core);
    #1;
    chk("done_ack_wrong_core", sn_done_ack, 0);
    core_sn_done_ack = 4'b0000;
    repeat (ack_delay) begin
      step();
      chk("done_hold", core_sn_done, oh(core));
      chk("done_ack_hold", sn_done_ack, 0);
    end
    core_sn_done_ack = oh(core);
    #1;
    chk("done_ack", sn_done_ack, 1);
    step();
    sn_done          = 1'b0;
    core_sn_done_ack = 4'b0000;
    exp_pkt++;
    chk("done_clr", core_sn_done, 0);
    chk("pkt_cnt", pkt_cnt, exp_pkt);
  endtask

  initial begin
    rst = 1'b0;
    core_en = 4'b1111;
    sn_addr = 8'h00;
    sn_wr_data = 64'h0;
    sn_wr_en = 1'b0;
    sn_byte_inc = 4'h0;
    sn_done = 1'b0;
    rdy_for_sn_ack = 1'b0;
    core_rdy_for_sn = 4'b0000;
    core_sn_done_ack = 4'b0000;

    // Reset state
    step();
    chk("rst_rdy", rdy_for_sn, 0);
    chk("rst_sel", cur_sel, 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_drop", drop_wr_cnt, 0);
    chk("rst_wr_en", core_sn_wr_en, 0);
    chk("rst_done", core_sn_done, 0);
    chk("rst_addr", core_sn_addr, 0);
    core_rdy_for_sn = 4'b1111;
    rst = 1'b1;

    // Round-robin across all four cores
    run_pkt(0, 3, 8'h10, 1'b0, 1'b0, 0);
    run_pkt(1, 3, 8'h20, 1'b0, 1'b0, 1);
    run_pkt(2, 3, 8'h30, 1'b0, 1'b0, 0);
    run_pkt(3, 3, 8'h40, 1'b0, 1'b0, 0);
    chk("rr_pkt_cnt", pkt_cnt, 4);

    // Write and done in the same cycle, ack delayed by the core
    run_pkt(0, 1, 8'h05, 1'b1, 1'b0, 2);

    // Enable mask 1010
    core_en = 4'b1010;
    run_pkt(1, 2, 8'h60, 1'b0, 1'b0, 0);
    run_pkt(3, 2, 8'h70, 1'b0, 1'b0, 0);
    run_pkt(1, 1, 8'h80, 1'b1, 1'b0, 0);
    run_pkt(3, 1, 8'h90, 1'b0, 1'b0, 0);
    core_en = 4'b1111;

    // Withdrawal before claim
    core_rdy_for_sn = 4'b0100;
    step();
    chk("wd_offer_rdy", rdy_for_sn, 1);
    chk("wd_offer_sel", cur_sel, 2);
    core_rdy_for_sn = 4'b0000;
    #1;
    chk("wd_no_claim", core_rdy_for_sn_ack, 0);
    step();
    chk("wd_rdy_fall", rdy_for_sn, 0);
    chk("wd_no_claim2", core_rdy_for_sn_ack, 0);
    step();
    chk("wd_stay_idle", rdy_for_sn, 0);
    chk("wd_pkt_cnt", pkt_cnt, exp_pkt);

    // Claim and withdrawal in the same cycle: the claim wins
    core_rdy_for_sn = 4'b0100;
    run_pkt(2, 2, 8'hA0, 1'b0, 1'b1, 0);

    // Stray acks and writes while idle
    rdy_for_sn_ack = 1'b1;
    #1;
    chk("stray_claim", core_rdy_for_sn_ack, 0);
    step();
    chk("stray_claim_rdy", rdy_for_sn, 0);
    rdy_for_sn_ack = 1'b0;
    sn_wr_en = 1'b1;
    repeat (5) begin
      step();
      chk("stray_no_strobe", core_sn_wr_en, 0);
    end
    chk("drop_5", drop_wr_cnt, 5);
    repeat (65530) step();
    chk("drop_max", drop_wr_cnt, 16'hFFFF);
    repeat (10) step();
    chk("drop_sat", drop_wr_cnt, 16'hFFFF);
    sn_wr_en = 1'b0;
    chk("pkt_after_stray", pkt_cnt, exp_pkt);

    // Reset while core 1 is in DONE
    core_rdy_for_sn = 4'b0010;
    step();
    chk("rd_sel", cur_sel, 1);
    rdy_for_sn_ack = 1'b1;
    step();
    rdy_for_sn_ack = 1'b0;
    sn_done = 1'b1;
    step();
    step();
    chk("rd_done_set", core_sn_done, 4'b0010);
    #2;
    rst = 1'b0;
    #1;
    chk("rd_done_clr", core_sn_done, 0);
    chk("rd_ack", sn_done_ack, 0);
    chk("rd_pkt", pkt_cnt, 0);
    chk("rd_drop", drop_wr_cnt, 0);
    chk("rd_sel0", cur_sel, 0);
    chk("rd_rdy", rdy_for_sn, 0);
    chk("rd_addr", core_sn_addr, 0);
    step();
    sn_done = 1'b0;
    core_rdy_for_sn = 4'b1111;
    step();
    rst = 1'b1;
    step();
    chk("rd_first_rdy", rdy_for_sn, 1);
    chk("rd_first_grant", cur_sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
